// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// The slave side is the unit itself. The master side is the execute stage
// together with the data memory.
interface load_store_unit_if;
    // execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // completion response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    // word-addressed data memory
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: converts one byte/half/word request at a time into
// word-aligned memory accesses. Sub-word stores are done as read-modify-write.
// Load data is lane-extracted and then sign- or zero-extended.
// Misaligned or illegal requests get a fault response and touch no memory.
module load_store_unit (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    // request fields latched at accept
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        fault_reg;
    // word captured during RD, and the last load result
    logic [31:0] word_reg;
    logic [31:0] rdata_reg;

    logic        accept;
    logic [1:0]  req_size;
    logic        req_illegal;
    logic        req_misaligned;
    logic        req_fault;

    logic [3:0]  lane_mask;
    logic [31:0] wdata_repl;
    logic [31:0] merged_word;
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        sign_ext;
    logic [31:0] load_ext;

    // Classify the incoming request. Size is funct3[1:0]: 00 byte, 01 half, 10 word.
    always_comb begin
        req_size = bus.req_funct3[1:0];
        if (bus.req_we) begin
            req_illegal = bus.req_funct3[2] | (req_size == 2'b11);
        end else begin
            req_illegal = (req_size == 2'b11) | (bus.req_funct3[2] & req_size[1]);
        end
        req_misaligned = ((req_size == 2'b01) & bus.req_addr[0]) |
                         ((req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
        req_fault = req_illegal | req_misaligned;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake/memory strobes. Memory strobes depend only on state.
    // They are forced low while rst is high.
    always_comb begin
        state_next     = state_reg;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (req_fault) begin
                        state_next = ST_RESP;
                    end else if (bus.req_we && (req_size == 2'b10)) begin
                        state_next = ST_WR;
                    end else begin
                        state_next = ST_RD;
                    end
                end
            end
            ST_RD: begin
                bus.mem_read = !rst;
                state_next   = we_reg ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                bus.mem_write = !rst;
                state_next    = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, read-word capture and load-result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= 32'h0;
            wdata_reg  <= 32'h0;
            fault_reg  <= 1'b0;
            word_reg   <= 32'h0;
            rdata_reg  <= 32'h0;
        end else begin
            if (accept) begin
                we_reg     <= bus.req_we;
                funct3_reg <= bus.req_funct3;
                addr_reg   <= bus.req_addr;
                wdata_reg  <= bus.req_wdata;
                fault_reg  <= req_fault;
            end
            if (state_reg == ST_RD) begin
                word_reg <= bus.mem_read_data;
                if (!we_reg) begin
                    rdata_reg <= load_ext;
                end
            end
        end
    end

    // Store lane select and replicated store data. A word store selects every lane,
    // so SW and SB/SH share the same merge path.
    always_comb begin
        lane_mask  = 4'b1111;
        wdata_repl = wdata_reg;
        case (funct3_reg[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << addr_reg[1:0];
                wdata_repl = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                lane_mask  = addr_reg[1] ? 4'b1100 : 4'b0011;
                wdata_repl = {2{wdata_reg[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                wdata_repl = wdata_reg;
            end
        endcase
    end

    // Per byte lane: merge store data over the captured word; split the read word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = lane_mask[gi] ? wdata_repl[8*gi +: 8]
                                                          : word_reg[8*gi +: 8];
            assign rd_byte[gi] = bus.mem_read_data[8*gi +: 8];
        end
    endgenerate

    // Load lane extraction and extension. funct3[2] set means unsigned (LBU/LHU).
    always_comb begin
        sel_byte = rd_byte[addr_reg[1:0]];
        sel_half = addr_reg[1] ? {rd_byte[3], rd_byte[2]} : {rd_byte[1], rd_byte[0]};
        sign_ext = ~funct3_reg[2];
        case (funct3_reg[1:0])
            2'b00:   load_ext = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            2'b01:   load_ext = {{16{sign_ext & sel_half[15]}}, sel_half};
            default: load_ext = bus.mem_read_data;
        endcase
    end

    // Memory address and data come only from latched fields, so they are stable all cycle.
    assign bus.mem_addr       = {addr_reg[31:2], 2'b00};
    assign bus.mem_write_data = merged_word;

    // Fault and store responses report zero data. The load result itself is held.
    assign bus.resp_fault = (state_reg == ST_RESP) & fault_reg;
    assign bus.resp_rdata = ((state_reg == ST_RESP) && (fault_reg || we_reg)) ? 32'h0
                                                                               : rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural data memory plus access counters
    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    logic [32:0] resp_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_write) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_read) rd_cnt <= rd_cnt + 1;
        if (bus.req_valid && bus.req_ready && !rst) acc_cnt <= acc_cnt + 1;
        if (bus.resp_valid) resp_q.push_back({bus.resp_fault, bus.resp_rdata});
    end

    always @(negedge clk) begin
        if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_addr[11:2]];
    end

    logic [31:0] r_data;
    logic        r_fault;
    int          r_lat;
    int          wr_base, rd_base, acc_base;
    int          acc_cyc [3];
    logic        got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE and take the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_valid  = 1'b1;
        check("ready_at_issue", {31'h0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Full transaction: records response data, fault and latency in cycles.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        issue(we, f3, a, d);
        r_lat   = 0;
        r_data  = 32'hxxxxxxxx;
        r_fault = 1'bx;
        for (int i = 1; i <= 8 && r_lat == 0; i++) begin
            if (bus.resp_valid) begin
                r_lat   = i;
                r_data  = bus.resp_rdata;
                r_fault = bus.resp_fault;
            end else begin
                tick();
            end
        end
        if (r_lat == 0) check({tag, "_timeout"}, 32'h0, 32'h1);
        $display("txn %s we=%0b f3=%03b addr=0x%08h rdata=0x%08h fault=%0b lat=%0d",
                 tag, we, f3, a, r_data, r_fault, r_lat);
        tick();
    endtask

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_funct3    = 3'b000;
        bus.req_addr      = 32'h0;
        bus.req_wdata     = 32'h0;
        bus.mem_read_data = 32'h0;

        // reset values
        tick(); tick();
        check("rst_ready",     {31'h0, bus.req_ready},  32'h1);
        check("rst_rvalid",    {31'h0, bus.resp_valid}, 32'h0);
        check("rst_fault",     {31'h0, bus.resp_fault}, 32'h0);
        check("rst_rdata",     bus.resp_rdata,          32'h0);
        check("rst_mread",     {31'h0, bus.mem_read},   32'h0);
        check("rst_mwrite",    {31'h0, bus.mem_write},  32'h0);
        check("rst_maddr",     bus.mem_addr,            32'h0);
        check("rst_mwdata",    bus.mem_write_data,      32'h0);
        rst = 1'b0;
        tick();

        // preload through the unit with word stores
        do_req("pre_400", 1'b1, 3'b010, 32'h400, 32'h11223344);
        check("pre_400_lat", r_lat, 2);
        do_req("pre_200", 1'b1, 3'b010, 32'h200, 32'h80FF7F01);
        do_req("pre_300", 1'b1, 3'b010, 32'h300, 32'hAABBCCDD);
        check("pre_300_mem", mem[32'h300 >> 2], 32'hAABBCCDD);

        // reset asserted while an SB is in WR
        wr_base = wr_cnt;
        issue(1'b1, 3'b000, 32'h401, 32'h55);
        check("sbrst_rd_mread", {31'h0, bus.mem_read}, 32'h1);
        check("sbrst_rd_maddr", bus.mem_addr, 32'h400);
        tick();
        check("sbrst_wr_mwrite", {31'h0, bus.mem_write}, 32'h1);
        check("sbrst_wr_wdata", bus.mem_write_data, 32'h11225544);
        rst = 1'b1;
        #1;
        check("sbrst_gated_mwrite", {31'h0, bus.mem_write}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("sbrst_ready",  {31'h0, bus.req_ready},  32'h1);
        check("sbrst_rvalid", {31'h0, bus.resp_valid}, 32'h0);
        check("sbrst_maddr",  bus.mem_addr,            32'h0);
        check("sbrst_mwdata", bus.mem_write_data,      32'h0);
        tick();
        check("sbrst_dropped", {31'h0, bus.resp_valid}, 32'h0);
        check("sbrst_mem",     mem[32'h400 >> 2],       32'h11223344);
        check("sbrst_wrcnt",   wr_cnt,                  wr_base);

        // SW 0x100 then LW 0x100, cycle by cycle
        wr_base = wr_cnt;
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        check("sw_mwrite", {31'h0, bus.mem_write}, 32'h1);
        check("sw_maddr",  bus.mem_addr,           32'h100);
        check("sw_wdata",  bus.mem_write_data,     32'hDEADBEEF);
        check("sw_wr_rv",  {31'h0, bus.resp_valid}, 32'h0);
        tick();
        check("sw_rvalid", {31'h0, bus.resp_valid}, 32'h1);
        check("sw_fault",  {31'h0, bus.resp_fault}, 32'h0);
        check("sw_rdata",  bus.resp_rdata,          32'h0);
        check("sw_mem",    mem[32'h100 >> 2],       32'hDEADBEEF);
        check("sw_wrcnt",  wr_cnt,                  wr_base + 1);
        $display("txn sw addr=0x00000100 data=0xdeadbeef");
        tick();
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        check("lw_mread",  {31'h0, bus.mem_read},   32'h1);
        check("lw_rd_rv",  {31'h0, bus.resp_valid}, 32'h0);
        tick();
        check("lw_rvalid", {31'h0, bus.resp_valid}, 32'h1);
        check("lw_rdata",  bus.resp_rdata,          32'hDEADBEEF);
        check("lw_fault",  {31'h0, bus.resp_fault}, 32'h0);
        $display("txn lw addr=0x00000100 rdata=0x%08h", bus.resp_rdata);
        tick();

        // signed / unsigned byte loads on 0x80FF7F01
        do_req("lb_203", 1'b0, 3'b000, 32'h203, 32'h0);
        check("lb_203_data", r_data, 32'hFFFFFF80);
        check("lb_203_lat",  r_lat,  2);
        do_req("lbu_203", 1'b0, 3'b100, 32'h203, 32'h0);
        check("lbu_203_data", r_data, 32'h00000080);
        do_req("lbu_201", 1'b0, 3'b100, 32'h201, 32'h0);
        check("lbu_201_data", r_data, 32'h0000007F);

        // SH 0x302 over 0xAABBCCDD: RD, WR, RESP
        issue(1'b1, 3'b001, 32'h302, 32'h00001234);
        check("sh_rd_mread",  {31'h0, bus.mem_read},  32'h1);
        check("sh_rd_mwrite", {31'h0, bus.mem_write}, 32'h0);
        tick();
        check("sh_wr_mwrite", {31'h0, bus.mem_write}, 32'h1);
        check("sh_wr_wdata",  bus.mem_write_data,     32'h1234CCDD);
        tick();
        check("sh_rvalid", {31'h0, bus.resp_valid}, 32'h1);
        check("sh_mem",    mem[32'h300 >> 2],       32'h1234CCDD);
        $display("txn sh addr=0x00000302 data=0x1234");
        tick();
        do_req("lh_302", 1'b0, 3'b001, 32'h302, 32'h0);
        check("lh_302_data", r_data, 32'h00001234);
        do_req("lh_300", 1'b0, 3'b001, 32'h300, 32'h0);
        check("lh_300_data", r_data, 32'hFFFFCCDD);
        do_req("sb_301", 1'b1, 3'b000, 32'h301, 32'hABCD00EE);
        check("sb_301_lat", r_lat, 3);
        check("sb_301_mem", mem[32'h300 >> 2], 32'h1234EEDD);
        do_req("lhu_300", 1'b0, 3'b101, 32'h300, 32'h0);
        check("lhu_300_data", r_data, 32'h0000EEDD);

        // faults: no memory access, latency 1, zero data
        wr_base = wr_cnt;
        rd_base = rd_cnt;
        do_req("lw_102", 1'b0, 3'b010, 32'h102, 32'h0);
        check("lw_102_fault", {31'h0, r_fault}, 32'h1);
        check("lw_102_lat",   r_lat,            1);
        check("lw_102_data",  r_data,           32'h0);
        do_req("sh_101", 1'b1, 3'b001, 32'h101, 32'h5555);
        check("sh_101_fault", {31'h0, r_fault}, 32'h1);
        check("sh_101_lat",   r_lat,            1);
        do_req("ld_f011", 1'b0, 3'b011, 32'h100, 32'h0);
        check("ld_f011_fault", {31'h0, r_fault}, 32'h1);
        check("ld_f011_data",  r_data,           32'h0);
        do_req("st_f100", 1'b1, 3'b100, 32'h100, 32'h0);
        check("st_f100_fault", {31'h0, r_fault}, 32'h1);
        check("fault_wrcnt", wr_cnt, wr_base);
        check("fault_rdcnt", rd_cnt, rd_base);
        check("rdata_held",  bus.resp_rdata, 32'h0000EEDD);

        // back-to-back with req_valid held high
        acc_base = acc_cnt;
        resp_q.delete();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100; bus.req_wdata = 32'h0; end
                1: begin bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h104; bus.req_wdata = 32'hCAFEF00D; end
                default: begin bus.req_we = 1'b0; bus.req_funct3 = 3'b100; bus.req_addr = 32'h100; bus.req_wdata = 32'h0; end
            endcase
            bus.req_valid = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                if (bus.req_ready) begin
                    tick();
                    acc_cyc[k] = cyc;
                    got = 1'b1;
                end else begin
                    tick();
                end
            end
            if (!got) check("b2b_accept_timeout", 32'h0, 32'h1);
        end
        bus.req_valid = 1'b0;
        for (int w = 0; w < 6; w++) tick();
        check("b2b_accepts", acc_cnt - acc_base, 3);
        check("b2b_gap01",   acc_cyc[1] - acc_cyc[0], 3);
        check("b2b_gap12",   acc_cyc[2] - acc_cyc[1], 3);
        check("b2b_nresp",   resp_q.size(), 3);
        if (resp_q.size() == 3) begin
            check("b2b_resp0", resp_q[0][31:0], 32'hDEADBEEF);
            check("b2b_resp1", resp_q[1][31:0], 32'h0);
            check("b2b_resp2", resp_q[2][31:0], 32'h000000EF);
            check("b2b_flt2",  {31'h0, resp_q[2][32]}, 32'h0);
        end
        check("b2b_mem104", mem[32'h104 >> 2], 32'hCAFEF00D);
        $display("txn b2b accepts at cycles %0d %0d %0d", acc_cyc[0], acc_cyc[1], acc_cyc[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the word-addressed data memory. Accepts one byte, halfword or word load/store request at a time and turns it into word-aligned memory reads and writes. Sub-word stores become read-modify-write sequences. Load data is extracted and sign- or zero-extended. Misaligned or illegal requests are rejected with a fault response and no memory access.

## Interface
Parameters:
- none; data and address widths are fixed at 32 bits.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH
- resp_valid  out  1  one-cycle pulse; the request is complete
- resp_rdata  out  32  extended load data; valid with resp_valid on loads, 0 on stores/faults
- resp_fault  out  1  valid with resp_valid; 1 = misaligned or illegal funct3
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00} to the data memory
- mem_write_data  out  32  full word to write
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_read_data  in  32  memory read word; the memory updates it on the falling edge of the cycle in which mem_read is high

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, the unit latches we, funct3, addr and wdata, then decodes:
  - Illegal funct3: load 011/110/111, or store with funct3[2]=1 or 011 → RESP with fault.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0 → RESP with fault.
  - Load → RD.
  - SW → WR.
  - SB/SH → RD.
- RD: mem_read=1.
  - At the rising edge the unit captures mem_read_data into an internal word register.
  - Load: extract lane by addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend; write to resp_rdata → RESP.
  - Store: → WR.
- WR: mem_write=1.
  - mem_write_data = wdata for SW.
  - SB/SH: captured word with the addressed byte or halfword lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged. → RESP.
- RESP: resp_valid=1, req_ready=0 → IDLE.
- mem_addr, mem_read, mem_write and mem_write_data decode from registered state and latched fields only, never from req_* inputs, so they are stable before the falling edge.
- mem_read and mem_write are gated by !rst; a cycle with rst high never writes memory.
- resp_fault=1 implies no memory access occurred and resp_rdata=0.
- Byte lanes are little-endian: lane n = bits [8n+7:8n].

## Timing
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0, captured word=0.
- Reset mid-operation (RD/WR/RESP): the unit returns to IDLE at that edge; any pending response is dropped.
- Latency is counted from the accept edge to the cycle with resp_valid high:
  - fault: 1
  - load, SW: 2
  - SB/SH: 3
- Throughput: one request per latency+1 cycles. A new request is accepted in the IDLE cycle following RESP.
- req_valid while req_ready=0 is ignored; the requester holds it.
- resp_rdata holds its value until the next load response or reset.

## Test plan
- Reset with the unit mid-SB (rst high in WR) → no memory write occurs; all outputs equal reset values; req_ready=1 on the next cycle.
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 → mem_write for one cycle at 0x100; resp_rdata=0xDEADBEEF two cycles after accept; resp_fault=0.
- LB 0x103 and LBU 0x103 on word 0x80FF7F01 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH 0x102 data 0x1234 over word 0xAABBCCDD → RD, WR and RESP sequence; the word becomes 0x1234CCDD; a following LH 0x102 returns 0x00001234.
- LW 0x102, SH 0x101, and load funct3=011 → resp_fault=1 one cycle after accept; mem_read and mem_write stay 0 throughout.
- Back-to-back: req_valid held high with three requests → each is accepted only when req_ready=1; exactly one resp_valid per request, in order.
